// File: rtl/mmu_int_pkg.sv
// Shared constants for the MMU-mapped interrupt controller: register map,
// FSM state encodings, STATUS bit positions and the default bus width.
package mmu_int_pkg;

    localparam int DATA_W_DEF = 24;

    localparam logic [1:0] ADDR_PEND   = 2'd0;
    localparam logic [1:0] ADDR_MASK   = 2'd1;
    localparam logic [1:0] ADDR_STATUS = 2'd2;
    localparam logic [1:0] ADDR_CTRL   = 2'd3;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] SVC  = 2'd2;

    localparam int STAT_REQ_BIT   = 3;
    localparam int STAT_INSVC_BIT = 4;

endpackage

// File: rtl/int_prio_enc.sv
// Fixed-priority encoder: reports the lowest set index of vec and whether any bit is set.
module int_prio_enc #(
    parameter int NUM_SRC = 8
) (
    input  logic [NUM_SRC-1:0] vec,
    output logic               valid,
    output logic [2:0]         idx
);

    // Scan from the top down so the lowest set index is the last one written.
    always_comb begin
        valid = 1'b0;
        idx   = 3'd0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (vec[i]) begin
                valid = 1'b1;
                idx   = 3'(i);
            end
        end
    end

endmodule

// File: rtl/mmu_int_ctrl.sv
// Interrupt controller: pending/mask/enable registers, fixed priority, req/ack/EOI handshake.
// Define INT_LEVEL_EN for level-sensitive sources; default is rising-edge capture.
module mmu_int_ctrl
    import mmu_int_pkg::*;
#(
    parameter int NUM_SRC = 8,
    parameter int DATA_W  = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_SRC-1:0] int_src,
    input  logic              CPU_en_int,
    input  logic              CPU_rw,
    input  logic [1:0]        CPU_addr,
    input  logic [DATA_W-1:0] din_mmu,
    output logic [DATA_W-1:0] dout_mmu,
    output logic              int_req,
    output logic [2:0]        int_id,
    input  logic              int_ack
);

    logic [NUM_SRC-1:0] pend_reg, pend_next;
    logic [NUM_SRC-1:0] mask_reg, mask_next;
    logic               enable_reg, enable_next;
    logic [NUM_SRC-1:0] src_q;
    logic [2:0]         id_q, id_next;
    logic [1:0]         state_reg, state_next;

    logic               wr_stb, eoi, ack_fire, in_service;
    logic [NUM_SRC-1:0] w1c, ack_clr, clr, eligible;
    logic [7:0]         ack_onehot, elig_next_pad;
    logic               enc_valid;
    logic [2:0]         enc_idx;

    assign wr_stb     = CPU_en_int & ~CPU_rw;
    assign eoi        = wr_stb && (CPU_addr == ADDR_STATUS) && (state_reg == SVC);
    assign ack_fire   = int_ack && (state_reg == REQ);
    assign in_service = (state_reg == SVC);
    assign int_req    = (state_reg == REQ);
    assign int_id     = id_q;

    assign w1c        = (wr_stb && CPU_addr == ADDR_PEND) ? din_mmu[NUM_SRC-1:0] : '0;
    assign ack_onehot = 8'd1 << id_q;
    assign ack_clr    = ack_fire ? ack_onehot[NUM_SRC-1:0] : '0;
    assign clr        = w1c | ack_clr;

`ifdef INT_LEVEL_EN
    assign pend_next = int_src;
    logic unused_lvl;
    assign unused_lvl = ^{clr, src_q};
`else
    // A new edge beats any clear landing on the same bit in the same cycle.
    assign pend_next = (pend_reg & ~clr) | (int_src & ~src_q);
`endif

    assign mask_next   = (wr_stb && CPU_addr == ADDR_MASK) ? din_mmu[NUM_SRC-1:0] : mask_reg;
    assign enable_next = (wr_stb && CPU_addr == ADDR_CTRL) ? din_mmu[0] : enable_reg;
    assign eligible    = pend_reg & mask_reg;

    // Look-ahead eligibility so a de-eligibling write drops int_req on the very next cycle.
    always_comb begin
        elig_next_pad = '0;
        elig_next_pad[NUM_SRC-1:0] = pend_next & mask_next & {NUM_SRC{enable_next}};
    end

    int_prio_enc #(.NUM_SRC(NUM_SRC)) u_prio (
        .vec   (eligible),
        .valid (enc_valid),
        .idx   (enc_idx)
    );

    always_comb begin
        state_next = state_reg;
        id_next    = id_q;
        case (state_reg)
            IDLE: begin
                if (enable_reg && enc_valid) begin
                    state_next = REQ;
                    id_next    = enc_idx;
                end
            end
            REQ: begin
                if (int_ack)
                    state_next = SVC;
                else if (!elig_next_pad[id_q])
                    state_next = IDLE;
            end
            SVC: begin
                if (eoi)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_reg   <= '0;
            mask_reg   <= '0;
            enable_reg <= 1'b0;
            src_q      <= '0;
            id_q       <= 3'd0;
            state_reg  <= IDLE;
        end else begin
            pend_reg   <= pend_next;
            mask_reg   <= mask_next;
            enable_reg <= enable_next;
            src_q      <= int_src;
            id_q       <= id_next;
            state_reg  <= state_next;
        end
    end

    always_comb begin
        dout_mmu = '0;
        case (CPU_addr)
            ADDR_PEND:   dout_mmu[NUM_SRC-1:0] = pend_reg;
            ADDR_MASK:   dout_mmu[NUM_SRC-1:0] = mask_reg;
            ADDR_STATUS: begin
                dout_mmu[STAT_INSVC_BIT] = in_service;
                dout_mmu[STAT_REQ_BIT]   = int_req;
                dout_mmu[2:0]            = id_q;
            end
            default:     dout_mmu[0] = enable_reg;
        endcase
    end

    logic unused_din;
    assign unused_din = ^din_mmu;

endmodule

// File: tb/tb_mmu_int_ctrl.sv
// Directed bench for mmu_int_ctrl (edge-capture build) with a queue-based scoreboard.
module tb_mmu_int_ctrl;
    import mmu_int_pkg::*;

    localparam int NS = 8;
    localparam int DW = 24;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [NS-1:0] int_src = '0;
    logic          CPU_en_int = 1'b0;
    logic          CPU_rw = 1'b1;
    logic [1:0]    CPU_addr = 2'd0;
    logic [DW-1:0] din_mmu = '0;
    logic [DW-1:0] dout_mmu;
    logic          int_req;
    logic [2:0]    int_id;
    logic          int_ack = 1'b0;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;
    exp_t sb[$];

    mmu_int_ctrl #(.NUM_SRC(NS), .DATA_W(DW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .int_src    (int_src),
        .CPU_en_int (CPU_en_int),
        .CPU_rw     (CPU_rw),
        .CPU_addr   (CPU_addr),
        .din_mmu    (din_mmu),
        .dout_mmu   (dout_mmu),
        .int_req    (int_req),
        .int_id     (int_id),
        .int_ack    (int_ack)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_val(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic observe(input logic [31:0] obs);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty observed=0x%0h expected=none", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                errors++;
                $error("FAIL %s observed=0x%0h expected=0x%0h", e.tag, obs, e.val);
            end
            $display("check %-22s observed=0x%0h expected=0x%0h", e.tag, obs, e.val);
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        expect_val(tag, exp);
        observe(obs);
    endtask

    task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string tag);
        CPU_en_int = 1'b1;
        CPU_rw     = 1'b1;
        CPU_addr   = a;
        expect_val(tag, exp);
        #1;
        observe(32'(dout_mmu));
        CPU_en_int = 1'b0;
        step();
    endtask

    task automatic wr(input logic [1:0] a, input logic [DW-1:0] d);
        CPU_en_int = 1'b1;
        CPU_rw     = 1'b0;
        CPU_addr   = a;
        din_mmu    = d;
        step();
        CPU_en_int = 1'b0;
        CPU_rw     = 1'b1;
    endtask

    task automatic pulse(input logic [NS-1:0] m);
        int_src = m;
        step();
        int_src = '0;
    endtask

    task automatic ack();
        int_ack = 1'b1;
        step();
        int_ack = 1'b0;
    endtask

    task automatic wait_req(input int budget, input string tag);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            step();
            seen = int_req;
        end
        check(tag, 32'(seen), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_int_req", 32'(int_req), 32'd0);
        rst_n = 1'b1;
        step();
        rd(ADDR_PEND,   32'h0, "rst_pend");
        rd(ADDR_STATUS, 32'h0, "rst_status");

        // Single event: edge at N, int_req at N+2
        wr(ADDR_MASK, 24'h01);
        wr(ADDR_CTRL, 24'h01);
        rd(ADDR_CTRL, 32'h1, "ctrl_rb");
        pulse(8'h01);
        check("lat_n1_req_low", 32'(int_req), 32'd0);
        step();
        check("lat_n2_req_high", 32'(int_req), 32'd1);
        check("lat_n2_id", 32'(int_id), 32'd0);
        rd(ADDR_STATUS, 32'h08, "status_req");
        ack();
        rd(ADDR_PEND,   32'h00, "ack_clears_pend");
        rd(ADDR_STATUS, 32'h10, "status_svc");
        wr(ADDR_STATUS, 24'h0);
        rd(ADDR_STATUS, 32'h00, "status_after_eoi");

        // Priority: sources 5 and 2 together
        wr(ADDR_MASK, 24'hFF);
        pulse(8'h24);
        step();
        check("prio_req", 32'(int_req), 32'd1);
        check("prio_first_id", 32'(int_id), 32'd2);
        rd(ADDR_PEND, 32'h24, "prio_pend");
        ack();
        wr(ADDR_STATUS, 24'h0);
        wait_req(5, "prio_second_req");
        check("prio_second_id", 32'(int_id), 32'd5);
        rd(ADDR_PEND, 32'h20, "prio_pend_left");
        ack();
        wr(ADDR_STATUS, 24'h0);

        // Masked event, then unmask
        wr(ADDR_MASK, 24'h00);
        pulse(8'h08);
        step();
        step();
        check("masked_no_req", 32'(int_req), 32'd0);
        rd(ADDR_PEND, 32'h08, "masked_pend");
        wr(ADDR_MASK, 24'h08);
        step();
        check("unmask_req", 32'(int_req), 32'd1);
        check("unmask_id", 32'(int_id), 32'd3);
        ack();
        wr(ADDR_STATUS, 24'h0);
        rd(ADDR_PEND, 32'h00, "unmask_pend_clr");

        // Race: W1C and new edge on the same bit
        wr(ADDR_MASK, 24'h00);
        pulse(8'h02);
        step();
        rd(ADDR_PEND, 32'h02, "race_pre");
        CPU_en_int = 1'b1;
        CPU_rw     = 1'b0;
        CPU_addr   = ADDR_PEND;
        din_mmu    = 24'h02;
        int_src    = 8'h02;
        step();
        CPU_en_int = 1'b0;
        CPU_rw     = 1'b1;
        rd(ADDR_PEND, 32'h02, "race_set_wins");
        wr(ADDR_PEND, 24'h02);
        rd(ADDR_PEND, 32'h00, "w1c_clears");
        int_src = '0;
        step();

        // Mask the requested source before ack
        wr(ADDR_MASK, 24'h02);
        pulse(8'h02);
        step();
        check("maskdrop_req", 32'(int_req), 32'd1);
        check("maskdrop_id", 32'(int_id), 32'd1);
        wr(ADDR_MASK, 24'h00);
        check("maskdrop_req_low", 32'(int_req), 32'd0);
        step();
        step();
        check("maskdrop_stays_low", 32'(int_req), 32'd0);
        rd(ADDR_STATUS, 32'h01, "maskdrop_status");

        // Ack and de-eligibling write in the same cycle: ack wins
        wr(ADDR_MASK, 24'h02);
        step();
        check("ackwin_req", 32'(int_req), 32'd1);
        int_ack    = 1'b1;
        CPU_en_int = 1'b1;
        CPU_rw     = 1'b0;
        CPU_addr   = ADDR_MASK;
        din_mmu    = 24'h00;
        step();
        int_ack    = 1'b0;
        CPU_en_int = 1'b0;
        CPU_rw     = 1'b1;
        rd(ADDR_STATUS, 32'h11, "ackwin_status");
        wr(ADDR_STATUS, 24'h0);
        rd(ADDR_STATUS, 32'h01, "ackwin_after_eoi");
        rd(ADDR_PEND,   32'h00, "ackwin_pend");

        // Level held high produces a single event
        wr(ADDR_MASK, 24'h01);
        int_src = 8'h01;
        wait_req(5, "held_req");
        ack();
        wr(ADDR_STATUS, 24'h0);
        repeat (4) step();
        check("held_no_retrigger", 32'(int_req), 32'd0);
        rd(ADDR_PEND, 32'h00, "held_pend");
        int_src = '0;
        step();

        // Asynchronous reset in the middle of REQ
        pulse(8'h01);
        step();
        check("pre_reset_req", 32'(int_req), 32'd1);
        rst_n = 1'b0;
        #1;
        check("async_reset_req", 32'(int_req), 32'd0);
        step();
        rst_n = 1'b1;
        step();
        rd(ADDR_PEND,   32'h0, "post_rst_pend");
        rd(ADDR_MASK,   32'h0, "post_rst_mask");
        rd(ADDR_STATUS, 32'h0, "post_rst_status");
        rd(ADDR_CTRL,   32'h0, "post_rst_ctrl");
        check("post_rst_id", 32'(int_id), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mmu_int_ctrl.md
Name: mmu_int_ctrl

Overview:
MMU-mapped interrupt controller on the receiving end of peripheral interrupt lines such as the timer's int_TCNT. It captures source events into a pending register, applies a mask and a fixed priority, and presents one interrupt ID to the CPU with a req/ack handshake. It then holds off further requests until the CPU writes end-of-interrupt (EOI). The register access bus is the same enable/addr/rw/din/dout bus the MMU drives to every peripheral.

Parameters:
NUM_SRC, 8, number of interrupt sources (1..8); index 0 has the highest priority.
DATA_W, 24, MMU data bus width.

Ports:
clk  in  1  system clock; all state updates on posedge.
rst_n  in  1  asynchronous reset, active-low.
int_src  in  NUM_SRC  peripheral interrupt lines; bit 0 is the timer int_TCNT.
CPU_en_int  in  1  MMU select for this block.
CPU_rw  in  1  1 = read, 0 = write.
CPU_addr  in  2  register select.
din_mmu  in  DATA_W  write data.
dout_mmu  out  DATA_W  read data (combinational).
int_req  out  1  interrupt request to the CPU.
int_id  out  3  ID of the requested or in-service source.
int_ack  in  1  CPU acknowledge, one-cycle pulse.

Behaviour:
- Reset (rst_n low, asynchronous):
  - PEND, MASK, ENABLE, src_q, id_q all cleared to 0; FSM goes to IDLE.
  - Outputs: int_req=0, int_id=0, dout_mmu reflects the zeroed registers.
- Register map (the write strobe is CPU_en_int & !CPU_rw):
  - addr 0 PEND: read returns pending bits, zero-extended. Write-1-to-clear on bits [NUM_SRC-1:0].
  - addr 1 MASK: read/write. A 1 enables the corresponding source.
  - addr 2 STATUS: read returns {in_service at bit 4, int_req at bit 3, id_q[2:0]}. Any write is EOI.
  - addr 3 CTRL: bit 0 is ENABLE (global enable), read/write.
  - Unused high bits read as 0.
  - dout_mmu is valid in the same cycle as the read; reads have no side effects.
- Capture (default mode):
  - src_q registers int_src every cycle.
  - PEND[i] is set on a rising edge, i.e. int_src[i] & !src_q[i].
  - When a set and a clear (W1C write or ack clear) hit the same bit in the same cycle, the set wins.
- Priority: eligible = PEND & MASK. The lowest-index eligible bit is selected.
- FSM:
  - IDLE: when ENABLE & |eligible, latch id_q = selected index and go to REQ. New events do not preempt a latched id.
  - REQ: int_req=1, int_id=id_q.
    - On int_ack: clear PEND[id_q] and go to SVC.
    - If eligible[id_q] drops (masked, W1C, or ENABLE cleared) before ack: go to IDLE, deasserting int_req on the next cycle.
  - SVC: int_req=0, in_service=1, int_id holds id_q. On an EOI write, go to IDLE.
  - int_ack outside REQ is ignored. EOI outside SVC is ignored.
  - If int_ack and a de-eligibling write occur in the same cycle, the ack wins.
- Latency: an input edge at cycle N sets PEND at N+1, the FSM enters REQ at N+2, and int_req is high during N+2.
- A source that stays high produces only one event. A level held high forever (e.g. timer divisor 0) does not re-trigger until it falls.

Optional Feature:
INT_LEVEL_EN
- Defined: sources are level-sensitive. PEND[i] = int_src[i] registered each cycle; W1C has no lasting effect while the level is high; the ack clear is likewise overridden by the level.
- Undefined: rising-edge capture as described above.

Decomposition:
- Package mmu_int_pkg holds:
  - register address constants ADDR_PEND/ADDR_MASK/ADDR_STATUS/ADDR_CTRL;
  - state enum IDLE/REQ/SVC;
  - STATUS bit positions;
  - DATA_W default.
- One sub-module, int_prio_enc: NUM_SRC-bit vector in, {valid, 3-bit index} out, lowest index wins, purely combinational.

Test Plan:
- Reset: rst_n low mid-REQ -> int_req=0 immediately; all registers read 0 after release.
- Single event: MASK=0x01, ENABLE=1, pulse int_src[0] at cycle N -> int_req high at N+2 with int_id=0. Ack -> PEND=0, STATUS=0x10. EOI -> STATUS=0x00.
- Priority: raise sources 5 and 2 in the same cycle, MASK=0xFF -> id 2 served first. After EOI, id 5 is requested.
- Masked event: MASK=0x00, pulse src 3 -> PEND=0x08, no int_req. Write MASK=0x08 -> int_req two cycles later with id 3.
- Race: W1C of PEND bit 1 in the same cycle as a new rising edge on src 1 -> PEND bit 1 remains 1. Mask source 1 while in REQ before ack -> int_req drops next cycle and the FSM returns to IDLE.
- INT_LEVEL_EN build: hold src 4 high, W1C PEND -> it reads 0x10 again next cycle; int_req reasserts after EOI.
